// File: rtl/ngx_http_parse_time_mul_pipe_acc.sv
// ngx_http_parse_time_mul_pipe_acc
//
// Pipelined integer multiplier with optional multiply-accumulate for the
// time-parsing datapath (seconds/minutes/days scaling). It accepts one
// operand pair per cycle. The result appears NUM_STAGE enabled clock edges
// after the sample is presented.
//
// Register chain, NUM_STAGE registers in total:
//   stage 1            : extended operands + valid/acc_clr tags (NUM_STAGE >= 2)
//   stages 2..N-1      : full-precision product + tags
//   stage N            : dout / vld_out (also the accumulator when ACC_EN=1)
// When NUM_STAGE == 1 the multiplier feeds the output register directly.
// When NUM_STAGE == 2 it sits between the operand and output registers.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset (clears data, tags, acc)
//   ce       in   clock enable; 0 freezes every register
//   vld_in   in   din0/din1/acc_clr are valid this cycle
//   acc_clr  in   with vld_in, restart the accumulator (ACC_EN=1 only)
//   din0     in   operand A, din0_WIDTH bits
//   din1     in   operand B, din1_WIDTH bits
//   vld_out  out  dout holds a newly completed result
//   dout     out  product or accumulated sum, dout_WIDTH bits
module ngx_http_parse_time_mul_pipe_acc #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 16,
    parameter int din1_WIDTH  = 14,
    parameter int dout_WIDTH  = 30,
    parameter int din0_SIGNED = 0,
    parameter int din1_SIGNED = 0,
    parameter int ACC_EN      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  vld_in,
    input  logic                  acc_clr,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  vld_out,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int P          = din0_WIDTH + din1_WIDTH;
    localparam int XW         = (dout_WIDTH > P) ? dout_WIDTH : P;
    localparam bit ANY_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);
    localparam int PD         = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 0;

    if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
        $error("ngx_http_parse_time_mul_pipe_acc[%0d]: NUM_STAGE=%0d outside 1..8", ID, NUM_STAGE);
    end

    // Extend both operands to the full product width. The product is only
    // ever used modulo 2^P, so one P-bit multiply gives the right bits for
    // every signed/unsigned combination.
    function automatic logic signed [P-1:0] ext0(input logic [din0_WIDTH-1:0] a);
        if (din0_SIGNED != 0) return P'($signed(a));
        else                  return P'(a);
    endfunction

    function automatic logic signed [P-1:0] ext1(input logic [din1_WIDTH-1:0] b);
        if (din1_SIGNED != 0) return P'($signed(b));
        else                  return P'(b);
    endfunction

    // Fit the product to dout_WIDTH. A narrower result keeps the low bits.
    // A wider result is sign-extended only when an operand is signed.
    function automatic logic [dout_WIDTH-1:0] resize_prod(input logic signed [P-1:0] p);
        logic [XW-1:0] x;
        if (ANY_SIGNED) x = XW'(p);
        else            x = XW'($unsigned(p));
        return x[dout_WIDTH-1:0];
    endfunction

    logic signed [P-1:0]   mul_a_p0;
    logic signed [P-1:0]   mul_b_p0;
    logic                  mul_vld_p0;
    logic                  mul_clr_p0;
    logic signed [P-1:0]   prod_p1;
    logic signed [P-1:0]   fin_prod;
    logic                  fin_vld;
    logic                  fin_clr;
    logic [dout_WIDTH-1:0] fin_res;
    logic [dout_WIDTH-1:0] dout_q;
    logic [dout_WIDTH-1:0] dout_d;
    logic                  vld_out_q;
    logic                  vld_out_d;

    // ---- stage 1: operand / tag register ----
    if (NUM_STAGE >= 2) begin : g_op_reg
        logic signed [P-1:0] op0_p0_q;
        logic signed [P-1:0] op1_p0_q;
        logic                vld_p0_q;
        logic                clr_p0_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                op0_p0_q <= '0;
                op1_p0_q <= '0;
                vld_p0_q <= 1'b0;
                clr_p0_q <= 1'b0;
            end else if (ce) begin
                op0_p0_q <= ext0(din0);
                op1_p0_q <= ext1(din1);
                vld_p0_q <= vld_in;
                clr_p0_q <= acc_clr;
            end
        end

        assign mul_a_p0   = op0_p0_q;
        assign mul_b_p0   = op1_p0_q;
        assign mul_vld_p0 = vld_p0_q;
        assign mul_clr_p0 = clr_p0_q;
    end else begin : g_op_direct
        assign mul_a_p0   = ext0(din0);
        assign mul_b_p0   = ext1(din1);
        assign mul_vld_p0 = vld_in;
        assign mul_clr_p0 = acc_clr;
    end

    assign prod_p1 = mul_a_p0 * mul_b_p0;

    // ---- stages 2..NUM_STAGE-1: product delay chain ----
    if (PD > 0) begin : g_prod_chain
        logic signed [P-1:0] prod_p1_q [PD];
        logic [PD-1:0]       vld_p1_q;
        logic [PD-1:0]       clr_p1_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < PD; i++) prod_p1_q[i] <= '0;
                vld_p1_q <= '0;
                clr_p1_q <= '0;
            end else if (ce) begin
                prod_p1_q[0] <= prod_p1;
                vld_p1_q[0]  <= mul_vld_p0;
                clr_p1_q[0]  <= mul_clr_p0;
                for (int i = 1; i < PD; i++) begin
                    prod_p1_q[i] <= prod_p1_q[i-1];
                    vld_p1_q[i]  <= vld_p1_q[i-1];
                    clr_p1_q[i]  <= clr_p1_q[i-1];
                end
            end
        end

        assign fin_prod = prod_p1_q[PD-1];
        assign fin_vld  = vld_p1_q[PD-1];
        assign fin_clr  = clr_p1_q[PD-1];
    end else begin : g_prod_direct
        assign fin_prod = prod_p1;
        assign fin_vld  = mul_vld_p0;
        assign fin_clr  = mul_clr_p0;
    end

    assign fin_res = resize_prod(fin_prod);

    // ---- stage NUM_STAGE: output register / accumulator ----
    // In accumulate mode dout_q is the accumulator itself. Invalid samples
    // leave it untouched, and the accumulator wraps modulo 2^dout_WIDTH.
    always_comb begin
        dout_d    = dout_q;
        vld_out_d = 1'b0;
        if (ACC_EN != 0) begin
            if (fin_vld) begin
                vld_out_d = 1'b1;
                dout_d    = fin_clr ? fin_res : dout_q + fin_res;
            end
        end else begin
            dout_d    = fin_res;
            vld_out_d = fin_vld;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q    <= '0;
            vld_out_q <= 1'b0;
        end else if (ce) begin
            dout_q    <= dout_d;
            vld_out_q <= vld_out_d;
        end
    end

    assign dout    = dout_q;
    assign vld_out = vld_out_q;

endmodule

// File: tb/tb_ngx_http_parse_time_mul_pipe_acc.sv
// Scoreboard bench for ngx_http_parse_time_mul_pipe_acc.
// Four instances are driven independently:
//   0: defaults (unsigned, NUM_STAGE=3)
//   1: both operands signed, NUM_STAGE=3
//   2: din0 signed only, NUM_STAGE=1
//   3: accumulate mode, NUM_STAGE=4
// Expected results are hand-computed constants pushed when a sample is
// issued. The monitor pops an entry and checks value and arrival cycle.
module tb_ngx_http_parse_time_mul_pipe_acc;

    typedef struct {
        logic [29:0] v;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [15:0] d0  [4];
    logic [13:0] d1  [4];
    logic        vi  [4];
    logic        clr [4];
    logic [29:0] dq  [4];
    logic        vq  [4];

    exp_t sbq [4][$];
    int   ns  [4] = '{3, 3, 1, 4};
    int   cnt     = 0;
    logic ce_s    = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    ngx_http_parse_time_mul_pipe_acc u_def (
        .clk(clk), .reset(reset), .ce(ce), .vld_in(vi[0]), .acc_clr(clr[0]),
        .din0(d0[0]), .din1(d1[0]), .vld_out(vq[0]), .dout(dq[0]));

    ngx_http_parse_time_mul_pipe_acc #(.din0_SIGNED(1), .din1_SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset), .ce(ce), .vld_in(vi[1]), .acc_clr(clr[1]),
        .din0(d0[1]), .din1(d1[1]), .vld_out(vq[1]), .dout(dq[1]));

    ngx_http_parse_time_mul_pipe_acc #(.NUM_STAGE(1), .din0_SIGNED(1)) u_mix (
        .clk(clk), .reset(reset), .ce(ce), .vld_in(vi[2]), .acc_clr(clr[2]),
        .din0(d0[2]), .din1(d1[2]), .vld_out(vq[2]), .dout(dq[2]));

    ngx_http_parse_time_mul_pipe_acc #(.NUM_STAGE(4), .ACC_EN(1)) u_acc (
        .clk(clk), .reset(reset), .ce(ce), .vld_in(vi[3]), .acc_clr(clr[3]),
        .din0(d0[3]), .din1(d1[3]), .vld_out(vq[3]), .dout(dq[3]));

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Count enabled edges; the monitor only treats vld_out as a new
    // result when the edge that produced it was enabled.
    always @(posedge clk) begin
        ce_s <= ce;
        if (ce) cnt <= cnt + 1;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ce_s && vq[k] === 1'b1) begin
                if (sbq[k].size() == 0) begin
                    check($sformatf("unexpected_result_dut%0d", k), 1, 0);
                end else begin
                    exp_t e;
                    e = sbq[k].pop_front();
                    check($sformatf("dout_dut%0d", k), dq[k], e.v);
                    check($sformatf("latency_dut%0d", k), cnt, e.due);
                end
            end else if (sbq[k].size() > 0 && sbq[k][0].due < cnt) begin
                exp_t e;
                e = sbq[k].pop_front();
                check($sformatf("late_result_dut%0d", k), cnt, e.due);
            end
        end
    end

    task automatic drive(input int k, input logic [15:0] a, input logic [13:0] b,
                         input logic v, input logic c, input logic [29:0] e);
        @(negedge clk);
        d0[k]  = a;
        d1[k]  = b;
        vi[k]  = v;
        clr[k] = c;
        if (v) sbq[k].push_back('{v: e, due: cnt + ns[k]});
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        vi[k]  = 1'b0;
        clr[k] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d0[k] = '0; d1[k] = '0; vi[k] = 1'b0; clr[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_dout_dut%0d", k), dq[k], 0);
            check($sformatf("reset_vld_dut%0d", k), vq[k], 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single max-operand product, then vld_out must drop again
        drive(0, 16'd65535, 14'd16383, 1'b1, 1'b0, 30'd1073659905);
        idle(0);
        repeat (3) @(negedge clk);
        check("single_pulse_drop", vq[0], 0);

        // Back-to-back, no bubbles (0x12345 is 14'h2345 on a 14-bit port)
        drive(0, 16'd1000, 14'd300, 1'b1, 1'b0, 30'd300000);
        drive(0, 16'd7, 14'd9, 1'b1, 1'b0, 30'd63);
        drive(0, 16'd0, 14'h2345, 1'b1, 1'b0, 30'd0);
        idle(0);
        repeat (4) @(negedge clk);

        // Signed x signed, including the two most negative operands
        drive(1, 16'hFFFE, 14'd3, 1'b1, 1'b0, 30'h3FFFFFFA);
        drive(1, 16'h8000, 14'h2000, 1'b1, 1'b0, 30'h10000000);
        idle(1);
        // Signed x unsigned, single-stage instance
        drive(2, 16'hFFFF, 14'd16383, 1'b1, 1'b0, 30'h3FFFC001);
        drive(2, 16'h8000, 14'd16383, 1'b1, 1'b0, 30'h20008000);
        drive(2, 16'd2, 14'd3, 1'b1, 1'b0, 30'd6);
        idle(2);
        repeat (5) @(negedge clk);

        // Stall mid-flight, then stall again while a result is on dout
        drive(0, 16'd5, 14'd5, 1'b1, 1'b0, 30'd25);
        drive(0, 16'd6, 14'd6, 1'b1, 1'b0, 30'd36);
        @(negedge clk);
        vi[0] = 1'b0;
        ce    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall1_vld", vq[0], 0);
        end
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall2_vld", vq[0], 1);
            check("stall2_dout", dq[0], 25);
        end
        ce = 1'b1;
        repeat (4) @(negedge clk);

        // Accumulate: clear, add, an ignored invalid clear, add, clear, wrap
        drive(3, 16'd10, 14'd10, 1'b1, 1'b1, 30'd100);
        drive(3, 16'd20, 14'd10, 1'b1, 1'b0, 30'd300);
        drive(3, 16'd77, 14'd77, 1'b0, 1'b1, 30'd0);
        drive(3, 16'd1, 14'd1, 1'b1, 1'b0, 30'd301);
        drive(3, 16'd3, 14'd3, 1'b1, 1'b1, 30'd9);
        drive(3, 16'd65535, 14'd16383, 1'b1, 1'b0, 30'd1073659914);
        drive(3, 16'd65535, 14'd16383, 1'b1, 1'b0, 30'd1073577995);
        idle(3);
        repeat (6) @(negedge clk);

        // Reset mid-flight: seed the accumulator, then put two samples in flight
        drive(3, 16'd4, 14'd4, 1'b1, 1'b1, 30'd16);
        idle(3);
        repeat (5) @(negedge clk);
        drive(0, 16'd100, 14'd2, 1'b1, 1'b0, 30'd200);
        drive(0, 16'd50, 14'd3, 1'b1, 1'b0, 30'd150);
        idle(0);
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) sbq[k].delete();
        check("async_reset_dout", dq[0], 0);
        check("async_reset_vld", vq[0], 0);
        check("async_reset_acc", dq[3], 0);
        @(negedge clk);
        reset = 1'b0;
        // First valid sample after reset accumulates onto 0, not onto 16
        drive(3, 16'd2, 14'd3, 1'b1, 1'b0, 30'd6);
        idle(3);
        repeat (10) @(negedge clk);

        for (int k = 0; k < 4; k++)
            check($sformatf("drain_dut%0d", k), sbq[k].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
